display_compositor: RTL and testbench

// - Pipelined, parametrised pixel colour compositor for the piano/waveform display path.
// - Takes NUM_LAYERS per-pixel hit flags from display generators (play highlight, white keys,

---
 rtl/display_compositor.sv | 133 +++++++++++++
 tb/tb_display_compositor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/display_compositor.sv
// Two-stage pixel compositor: per-layer blink masking and priority select, then a
// palette lookup. The palette is double-buffered and swaps on frame_start.
module display_compositor #(
  parameter int NUM_LAYERS   = 5,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 30,
  localparam int ADDR_W      = $clog2(NUM_LAYERS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   valid_in,
  input  logic [NUM_LAYERS-1:0]  layer_hit,
  input  logic [NUM_LAYERS-1:0]  blink_en,
  input  logic                   pal_we,
  input  logic [ADDR_W-1:0]      pal_addr,
  input  logic [3*COLOR_W-1:0]   pal_data,
  output logic                   valid_out,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b
);

  localparam int PIX_W       = 3 * COLOR_W;
  localparam int NUM_ENTRIES = NUM_LAYERS + 1;
  localparam int CNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [COLOR_W-1:0] BG_CH    = {{(COLOR_W-1){1'b0}}, 1'b1} << (COLOR_W - 3);
  localparam logic [PIX_W-1:0]   BG_RST   = {3{BG_CH}};
  localparam logic [PIX_W-1:0]   LAYER_RST = {PIX_W{1'b1}};

  logic [NUM_ENTRIES-1:0][PIX_W-1:0] shadow_vec;
  logic [NUM_ENTRIES-1:0][PIX_W-1:0] active_vec;

  logic [CNT_W-1:0]      frame_cnt_reg;
  logic                  blink_phase_reg;
  logic [NUM_LAYERS-1:0] eff_hit;
  logic [ADDR_W-1:0]     sel_next;
  logic [ADDR_W-1:0]     s1_sel_reg;
  logic                  s1_valid_reg;
  logic [PIX_W-1:0]      pal_rd_next;
  logic                  valid_out_reg;
  logic [PIX_W-1:0]      rgb_reg;

  // Each palette entry owns its shadow and active copy; addresses above the
  // background entry match nothing, so such writes fall away.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_pal
      localparam logic [PIX_W-1:0] RST_VAL = (gi == NUM_LAYERS) ? BG_RST : LAYER_RST;
      logic [PIX_W-1:0] shadow_reg;
      logic [PIX_W-1:0] active_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_reg <= RST_VAL;
          active_reg <= RST_VAL;
        end else begin
          if (frame_start)
            active_reg <= shadow_reg;
          if (pal_we && (pal_addr == ADDR_W'(gi)))
            shadow_reg <= pal_data;
        end
      end

      assign shadow_vec[gi] = shadow_reg;
      assign active_vec[gi] = active_reg;
    end

    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
      assign eff_hit[gi] = layer_hit[gi] & ~(blink_en[gi] & ~blink_phase_reg);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt_reg == LAST_CNT) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Scan from the lowest priority upward so the lowest hit index wins.
  always_comb begin
    sel_next = ADDR_W'(NUM_LAYERS);
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (eff_hit[k])
        sel_next = ADDR_W'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_sel_reg   <= ADDR_W'(NUM_LAYERS);
    end else begin
      s1_valid_reg <= valid_in;
      s1_sel_reg   <= sel_next;
    end
  end

  // A palette swap on this edge is bypassed so stage 2 sees the new active colour.
  always_comb begin
    pal_rd_next = active_vec[s1_sel_reg];
    if (frame_start)
      pal_rd_next = shadow_vec[s1_sel_reg];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out_reg <= 1'b0;
      rgb_reg       <= '0;
    end else if (s1_valid_reg) begin
      valid_out_reg <= 1'b1;
      rgb_reg       <= pal_rd_next;
    end else begin
      valid_out_reg <= 1'b0;
      rgb_reg       <= '0;
    end
  end

  assign valid_out = valid_out_reg;
  assign r = rgb_reg[3*COLOR_W-1:2*COLOR_W];
  assign g = rgb_reg[2*COLOR_W-1:COLOR_W];
  assign b = rgb_reg[COLOR_W-1:0];

endmodule

// File: tb/tb_display_compositor.sv
// Bench for display_compositor: directed table, palette/blink/reset sequences, and
// randomized traffic compared against a frame-level reference model.
module tb_display_compositor;
  localparam int NL = 5;
  localparam int CW = 8;
  localparam int BF = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_start = 1'b0;
  logic valid_in = 1'b0;
  logic pal_we = 1'b0;
  logic [NL-1:0] layer_hit = '0;
  logic [NL-1:0] blink_en = '0;
  logic [AW-1:0] pal_addr = '0;
  logic [3*CW-1:0] pal_data = '0;
  logic valid_out;
  logic [CW-1:0] r, g, b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .valid_in(valid_in),
    .layer_hit(layer_hit), .blink_en(blink_en), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data),
    .valid_out(valid_out), .r(r), .g(g), .b(b)
  );

  // Reference model: palette as two colour tables, blink as a frame counter,
  // pipeline as the pixel currently waiting for its colour.
  logic [23:0] m_shadow [NL+1];
  logic [23:0] m_active [NL+1];
  int          m_cnt;
  bit          m_phase;
  bit          m_v1;
  int          m_sel1;
  bit          m_vo;
  logic [23:0] m_rgb;

  function automatic void model_reset();
    for (int k = 0; k <= NL; k++) begin
      m_shadow[k] = (k == NL) ? 24'h202020 : 24'hFFFFFF;
      m_active[k] = m_shadow[k];
    end
    m_cnt = 0; m_phase = 1'b1;
    m_v1 = 1'b0; m_sel1 = NL; m_vo = 1'b0; m_rgb = '0;
  endfunction

  function automatic int pick(input logic [NL-1:0] h, input logic [NL-1:0] be, input bit ph);
    for (int k = 0; k < NL; k++)
      if (h[k] && !(be[k] && !ph)) return k;
    return NL;
  endfunction

  task automatic step(input bit v, input logic [NL-1:0] h, input logic [NL-1:0] be,
                      input bit fs, input bit we, input logic [AW-1:0] a, input logic [23:0] d);
    int ns;
    valid_in = v; layer_hit = h; blink_en = be; frame_start = fs;
    pal_we = we; pal_addr = a; pal_data = d;
    @(posedge clk);
    ns = pick(h, be, m_phase);
    m_vo = m_v1;
    m_rgb = m_v1 ? (fs ? m_shadow[m_sel1] : m_active[m_sel1]) : 24'h0;
    m_v1 = v; m_sel1 = ns;
    if (fs) begin
      for (int k = 0; k <= NL; k++) m_active[k] = m_shadow[k];
      if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = !m_phase; end
      else m_cnt++;
    end
    if (we && a <= AW'(NL)) m_shadow[a] = d;
    #1;
  endtask

  task automatic check_exp(input string name, input bit ev, input logic [23:0] erg);
    checks++;
    if (valid_out !== ev || {r, g, b} !== erg) begin
      failures++;
      $display("FAIL %s: got valid=%0b rgb=%06h, required valid=%0b rgb=%06h",
               name, valid_out, {r, g, b}, ev, erg);
    end else
      $display("[%0t] %s valid=%0b rgb=%06h", $time, name, valid_out, {r, g, b});
  endtask

  task automatic check_model(input string name);
    checks++;
    if (valid_out !== m_vo || {r, g, b} !== m_rgb) begin
      failures++;
      $display("FAIL %s: got valid=%0b rgb=%06h, model valid=%0b rgb=%06h",
               name, valid_out, {r, g, b}, m_vo, m_rgb);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 24'h0);
  endtask

  task automatic probe(input string name, input logic [NL-1:0] h, input logic [NL-1:0] be,
                       input logic [23:0] erg);
    step(1'b1, h, be, 1'b0, 1'b0, '0, 24'h0);
    idle();
    check_exp(name, 1'b1, erg);
    check_model({name, "_model"});
  endtask

  typedef struct {
    bit          v;
    logic [NL-1:0] hit;
    bit          ev;
    logic [23:0] erg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 5'b00000, 1'b1, 24'h202020};
    tbl[1] = '{1'b1, 5'b01010, 1'b1, 24'h112233};
    tbl[2] = '{1'b1, 5'b10000, 1'b1, 24'hAABBCC};
    tbl[3] = '{1'b0, 5'b00001, 1'b0, 24'h000000};
    tbl[4] = '{1'b1, 5'b00100, 1'b1, 24'h445566};
    tbl[5] = '{1'b1, 5'b01000, 1'b1, 24'h778899};
    tbl[6] = '{1'b0, 5'b11111, 1'b0, 24'h000000};
    tbl[7] = '{1'b1, 5'b11110, 1'b1, 24'h112233};

    model_reset();
    repeat (2) @(posedge clk);
    #1 check_exp("reset_state", 1'b0, 24'h0);
    @(negedge clk) reset = 1'b1;

    // Background colour appears two clocks after the first active pixel.
    step(1'b1, '0, '0, 1'b0, 1'b0, '0, 24'h0);
    check_exp("first_latency_1", 1'b0, 24'h0);
    idle();
    check_exp("first_bg", 1'b1, 24'h202020);

    // Give layers 1..4 distinct colours, then swap them in.
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd1, 24'h112233);
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd2, 24'h445566);
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd3, 24'h778899);
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd4, 24'hAABBCC);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 24'h0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].hit, '0, 1'b0, 1'b0, '0, 24'h0);
      if (i > 0) check_exp($sformatf("tbl%0d", i - 1), tbl[i-1].ev, tbl[i-1].erg);
    end
    idle();
    check_exp("tbl7", tbl[7].ev, tbl[7].erg);

    // Mid-frame write stays hidden until the next frame_start.
    probe("l0_before_write", 5'b00001, '0, 24'hFFFFFF);
    step(1'b1, 5'b00001, '0, 1'b0, 1'b1, 3'd0, 24'h7697C7);
    idle();
    check_exp("l0_write_cycle", 1'b1, 24'hFFFFFF);
    probe("l0_after_write", 5'b00001, '0, 24'hFFFFFF);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 24'h0);
    probe("l0_after_fs", 5'b00001, '0, 24'h7697C7);

    // Write coincident with frame_start lands one frame later.
    step(1'b0, '0, '0, 1'b1, 1'b1, 3'd0, 24'h0A0B0C);
    probe("l0_coinc_fs", 5'b00001, '0, 24'h7697C7);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 24'h0);
    probe("l0_next_fs", 5'b00001, '0, 24'h0A0B0C);

    // Out-of-range addresses must not touch any entry.
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd6, 24'h000000);
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd7, 24'h000000);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 24'h0);
    probe("bad_addr_l0", 5'b00001, '0, 24'h0A0B0C);
    probe("bad_addr_l1", 5'b00010, '0, 24'h112233);
    probe("bad_addr_l4", 5'b10000, '0, 24'hAABBCC);
    probe("bad_addr_bg", 5'b00000, '0, 24'h202020);

    // Asynchronous reset in the middle of active pixels.
    step(1'b1, 5'b00001, '0, 1'b0, 1'b0, '0, 24'h0);
    step(1'b1, 5'b00001, '0, 1'b0, 1'b0, '0, 24'h0);
    check_exp("pre_reset", 1'b1, 24'h0A0B0C);
    #2 reset = 1'b0;
    #1 check_exp("async_reset", 1'b0, 24'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    step(1'b1, 5'b00001, '0, 1'b0, 1'b0, '0, 24'h0);
    check_exp("post_reset_1", 1'b0, 24'h0);
    idle();
    check_exp("post_reset_l0", 1'b1, 24'hFFFFFF);

    // Blink: layer 0 hidden on alternate pairs of frames, exposing layer 1.
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'd1, 24'h112233);
    for (int f = 0; f < 5; f++) begin
      probe($sformatf("blink_frame%0d", f), 5'b00011, 5'b00001,
            (((f / 2) % 2) == 0) ? 24'hFFFFFF : 24'h112233);
      step(1'b0, '0, '0, 1'b1, 1'b0, '0, 24'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, NL'($urandom), NL'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           AW'($urandom_range(0, 7)), 24'($urandom));
      check_model($sformatf("rand%0d", n));
    end
    $display("[%0t] random phase done, %0d cycles", $time, 1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
